alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

Decode/issue stage that sits directly in front of the EX-stage ALU in the RISC_TOY pipeline. It accepts fetched instructions through a valid/ready handshake, decodes the opcode into the 4-bit ALU operation code, and selects the two 32-bit operands from register-file read data or a sign-extended immediate. It drives the registered ID/EX outputs (`ALUOP_E`, `ALUSRC1`, `ALUSRC2`, destination and write-enable). A one-entry skid buffer absorbs EX stalls so that `IN_READY` is never combinationally dependent on `EX_STALL`.

## Interface
Parameters:
- `DW`, 32, datapath width. Only 32 is supported.
- `RW`, 5, register address width.

Ports:
- `CLK`  in  1  single clock.
- `RST`  in  1  reset; **synchronous, active-high**.
- `IN_VALID`  in  1  instruction valid.
- `IN_READY`  out  1  stage can accept an instruction.
- `INSTR`  in  32  instruction word.
- `RS1_ADDR`, `RS2_ADDR`  out  5  combinational register-file read addresses, equal to `INSTR[21:17]` and `INSTR[16:12]`.
- `RS1_DATA`, `RS2_DATA`  in  32  register-file read data, valid in the same cycle.
- `EX_STALL`  in  1  EX stage cannot consume this cycle.
- `FLUSH`  in  1  discard all held and in-flight instructions.
- `ALUOUT_E`  in  32  current ALU result. Used only when `ALU_ISSUE_FWD_EN` is defined.
- `VALID_E`  out  1  ID/EX contents are valid.
- `ALUOP_E`  out  4  ALU operation code.
- `ALUSRC1`, `ALUSRC2`  out  32  ALU operands.
- `RD_E`  out  5  destination register, `INSTR[26:22]`.
- `WE_E`  out  1  register write enable.
- `ILLEGAL_E`  out  1  the issued opcode is illegal.

## Operation
Instruction fields:
- `op` = `[31:27]`, `ra` = `[26:22]`, `rb` = `[21:17]`, `rc` = `[16:12]`.
- `imm` = `[16:0]`, sign-extended to 32 bits.

Opcode decode, listed as opcode → `ALUOP_E`, SRC1, SRC2:
- 0 NOP → 0, 0, 0; `WE_E` = 0.
- 1 ADDI → 1, rb, imm.
- 2 ANDI → 5, rb, imm.
- 3 ORI → 6, rb, imm.
- 4 MOVI → 12, 0, imm.
- 5 ADD → 1, rb, rc.
- 6 SUB → 2, rb, rc.
- 7 NEG → 3, 0, rc.
- 8 NOT → 4, 0, rc.
- 9 AND → 5, rb, rc.
- 10 OR → 6, rb, rc.
- 11 XOR → 7, rb, rc.
- 12 LSR → 8, rb, rc.
- 13 ASR → 9, rb, rc.
- 14 SHL → 10, rb, rc.
- 15 ROR → 11, rb, rc.
- 16–31 are illegal: `ALUOP_E` = 0, operands 0, `WE_E` = 0, `ILLEGAL_E` = 1.

`WE_E` = 1 for opcodes 1–15.

Decoding and operand capture happen at accept time (`IN_VALID & IN_READY`). The skid entry stores decoded values, not raw instructions.

Buffer state machine:
- **EMPTY**: ID/EX invalid, skid empty. `IN_READY` = 1.
- **HOLD**: ID/EX valid, skid empty. `IN_READY` = 1.
- **FULL**: ID/EX valid, skid valid. `IN_READY` = 0.

Transitions (accept = handshake, drain = `VALID_E & !EX_STALL`):
- EMPTY + accept → HOLD.
- HOLD + accept + drain → HOLD, with the new instruction loaded into ID/EX.
- HOLD + accept + stall → FULL, with the new instruction loaded into the skid.
- HOLD + drain, no accept → EMPTY.
- FULL + drain → HOLD, skid moves to ID/EX.
- FULL + stall → FULL, contents unchanged.

Other rules:
- `FLUSH` → EMPTY in the next cycle; accept is ignored in the flush cycle.
- `RST` has priority over `FLUSH`.
- While `VALID_E` = 0, all E outputs are 0.
- RAW hazards older than the instruction currently in ID/EX are handled by the pipeline hazard unit, not by this block.

## Timing
- Every output is registered except `RS1_ADDR` and `RS2_ADDR`.
- Reset values: `VALID_E`, `ALUOP_E`, `ALUSRC1`, `ALUSRC2`, `RD_E`, `WE_E`, `ILLEGAL_E` are all 0.
- `IN_READY` is 1 from the first cycle after `RST` deasserts.
- Latency: an accept at cycle n gives `VALID_E` = 1 at n+1 when the stage is not stalled.
- Throughput: 1 instruction/cycle.
- `IN_READY` depends only on registered state.
- Outputs hold stable while `VALID_E & EX_STALL`.
- `RST` or `FLUSH` arriving while FULL discards both entries with no partial drain.

## Configuration
Macro: `ALU_ISSUE_FWD_EN`.
- **Defined:** at accept, for each register operand, if `VALID_E & WE_E & !EX_STALL` and the source address equals `RD_E`, the operand is taken from `ALUOUT_E` instead of `RSx_DATA`. Immediate operands are never forwarded.
- **Undefined:** `ALUOUT_E` is unused and operands always come from `RSx_DATA`.

## Structure
- Package `risc_toy_pkg`:
  - opcode localparams `OP_NOP` … `OP_ROR`;
  - ALU code localparams `ALU_NOP` = 0 … `ALU_PASS2` = 12;
  - packed struct `issue_t` holding `aluop`, `src1`, `src2`, `rd`, `we`, `illegal`.
- One sub-module, `alu_issue_decode`: combinational, maps `INSTR` plus read data to `issue_t`.
- The top module holds the state machine, the skid buffer, the ID/EX register and forwarding.

## Test plan
- **ADD decode:** r2 = 5, r3 = 7, `INSTR` = ADD ra=1 rb=2 rc=3 → next cycle `VALID_E` = 1, `ALUOP_E` = 1, `ALUSRC1` = 5, `ALUSRC2` = 7, `RD_E` = 1, `WE_E` = 1.
- **Immediate sign-extension:** ADDI rb=4 (value 10), imm = 0x1FFFF → `ALUSRC2` = 0xFFFFFFFF, `ALUOP_E` = 1.
- **Stall and skid:** hold `EX_STALL` = 1 over two accepts → FULL, `IN_READY` = 0, first op held stable. Release → ops issue in order on consecutive cycles, `IN_READY` = 1 one cycle after release.
- **Illegal opcode:** op = 20 → `ILLEGAL_E` = 1, `WE_E` = 0, `ALUOP_E` = 0.
- **Flush in FULL:** assert `FLUSH` while FULL → next cycle `VALID_E` = 0, `IN_READY` = 1, and the skid op never issues.
- **Forwarding (with `ALU_ISSUE_FWD_EN`):** SUB ra=6 in ID/EX with `ALUOUT_E` = 0x1234, next instruction AND rb=6 with `RS1_DATA` = 0 → `ALUSRC1` = 0x1234. Without the macro → `ALUSRC1` = 0.

Source files
------------

// File: rtl/risc_toy_pkg.sv
// rtl/risc_toy_pkg.sv - opcode/ALU code constants and the decoded issue record for the RISC_TOY issue stage
package risc_toy_pkg;

   localparam logic [4:0] OP_NOP  = 5'd0;
   localparam logic [4:0] OP_ADDI = 5'd1;
   localparam logic [4:0] OP_ANDI = 5'd2;
   localparam logic [4:0] OP_ORI  = 5'd3;
   localparam logic [4:0] OP_MOVI = 5'd4;
   localparam logic [4:0] OP_ADD  = 5'd5;
   localparam logic [4:0] OP_SUB  = 5'd6;
   localparam logic [4:0] OP_NEG  = 5'd7;
   localparam logic [4:0] OP_NOT  = 5'd8;
   localparam logic [4:0] OP_AND  = 5'd9;
   localparam logic [4:0] OP_OR   = 5'd10;
   localparam logic [4:0] OP_XOR  = 5'd11;
   localparam logic [4:0] OP_LSR  = 5'd12;
   localparam logic [4:0] OP_ASR  = 5'd13;
   localparam logic [4:0] OP_SHL  = 5'd14;
   localparam logic [4:0] OP_ROR  = 5'd15;

   localparam logic [3:0] ALU_NOP   = 4'd0;
   localparam logic [3:0] ALU_ADD   = 4'd1;
   localparam logic [3:0] ALU_SUB   = 4'd2;
   localparam logic [3:0] ALU_NEG   = 4'd3;
   localparam logic [3:0] ALU_NOT   = 4'd4;
   localparam logic [3:0] ALU_AND   = 4'd5;
   localparam logic [3:0] ALU_OR    = 4'd6;
   localparam logic [3:0] ALU_XOR   = 4'd7;
   localparam logic [3:0] ALU_LSR   = 4'd8;
   localparam logic [3:0] ALU_ASR   = 4'd9;
   localparam logic [3:0] ALU_SHL   = 4'd10;
   localparam logic [3:0] ALU_ROR   = 4'd11;
   localparam logic [3:0] ALU_PASS2 = 4'd12;

   typedef struct packed {
      logic [3:0]  aluop;
      logic [31:0] src1;
      logic [31:0] src2;
      logic [4:0]  rd;
      logic        we;
      logic        illegal;
   } issue_t;

endpackage

// File: rtl/alu_issue_stage_if.sv
// rtl/alu_issue_stage_if.sv - instruction handshake, register-file read and ID/EX output bundle
interface alu_issue_stage_if #(
   parameter int DW = 32,
   parameter int RW = 5
);
   logic          IN_VALID;
   logic          IN_READY;
   logic [DW-1:0] INSTR;
   logic [RW-1:0] RS1_ADDR;
   logic [RW-1:0] RS2_ADDR;
   logic [DW-1:0] RS1_DATA;
   logic [DW-1:0] RS2_DATA;
   logic          EX_STALL;
   logic          FLUSH;
   logic [DW-1:0] ALUOUT_E;
   logic          VALID_E;
   logic [3:0]    ALUOP_E;
   logic [DW-1:0] ALUSRC1;
   logic [DW-1:0] ALUSRC2;
   logic [RW-1:0] RD_E;
   logic          WE_E;
   logic          ILLEGAL_E;

   modport master (
      output IN_VALID, INSTR, RS1_DATA, RS2_DATA, EX_STALL, FLUSH, ALUOUT_E,
      input  IN_READY, RS1_ADDR, RS2_ADDR, VALID_E, ALUOP_E, ALUSRC1, ALUSRC2,
             RD_E, WE_E, ILLEGAL_E
   );

   modport slave (
      input  IN_VALID, INSTR, RS1_DATA, RS2_DATA, EX_STALL, FLUSH, ALUOUT_E,
      output IN_READY, RS1_ADDR, RS2_ADDR, VALID_E, ALUOP_E, ALUSRC1, ALUSRC2,
             RD_E, WE_E, ILLEGAL_E
   );
endinterface

// File: rtl/alu_issue_decode.sv
// rtl/alu_issue_decode.sv - combinational opcode decode and operand select into issue_t
module alu_issue_decode
   import risc_toy_pkg::*;
(
   input  logic [31:0] instr,
   input  logic [31:0] rs1_data,
   input  logic [31:0] rs2_data,
   output issue_t      dec
);

   logic [4:0]  op;
   logic [31:0] imm;

   assign op  = instr[31:27];
   assign imm = {{15{instr[16]}}, instr[16:0]};

   always_comb begin
      dec       = '0;
      dec.rd    = instr[26:22];
      dec.we    = 1'b1;
      case (op)
         OP_NOP:  dec.we = 1'b0;
         OP_ADDI: begin dec.aluop = ALU_ADD;   dec.src1 = rs1_data; dec.src2 = imm;      end
         OP_ANDI: begin dec.aluop = ALU_AND;   dec.src1 = rs1_data; dec.src2 = imm;      end
         OP_ORI:  begin dec.aluop = ALU_OR;    dec.src1 = rs1_data; dec.src2 = imm;      end
         OP_MOVI: begin dec.aluop = ALU_PASS2;                      dec.src2 = imm;      end
         OP_ADD:  begin dec.aluop = ALU_ADD;   dec.src1 = rs1_data; dec.src2 = rs2_data; end
         OP_SUB:  begin dec.aluop = ALU_SUB;   dec.src1 = rs1_data; dec.src2 = rs2_data; end
         OP_NEG:  begin dec.aluop = ALU_NEG;                        dec.src2 = rs2_data; end
         OP_NOT:  begin dec.aluop = ALU_NOT;                        dec.src2 = rs2_data; end
         OP_AND:  begin dec.aluop = ALU_AND;   dec.src1 = rs1_data; dec.src2 = rs2_data; end
         OP_OR:   begin dec.aluop = ALU_OR;    dec.src1 = rs1_data; dec.src2 = rs2_data; end
         OP_XOR:  begin dec.aluop = ALU_XOR;   dec.src1 = rs1_data; dec.src2 = rs2_data; end
         OP_LSR:  begin dec.aluop = ALU_LSR;   dec.src1 = rs1_data; dec.src2 = rs2_data; end
         OP_ASR:  begin dec.aluop = ALU_ASR;   dec.src1 = rs1_data; dec.src2 = rs2_data; end
         OP_SHL:  begin dec.aluop = ALU_SHL;   dec.src1 = rs1_data; dec.src2 = rs2_data; end
         OP_ROR:  begin dec.aluop = ALU_ROR;   dec.src1 = rs1_data; dec.src2 = rs2_data; end
         default: begin dec.we = 1'b0; dec.illegal = 1'b1; end
      endcase
   end

endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - decode/issue stage with one-entry skid buffer in front of the EX ALU
// Optional ALU_ISSUE_FWD_EN: forward ALUOUT_E into register operands at accept time.
module alu_issue_stage
   import risc_toy_pkg::*;
#(
   parameter int DW = 32,
   parameter int RW = 5
) (
   input logic CLK,
   input logic RST,
   alu_issue_stage_if.slave bus
);

   // Bit 0 = ID/EX valid, bit 1 = skid valid, so outputs come straight off flops.
   typedef enum logic [1:0] {
      S_EMPTY = 2'b00,
      S_HOLD  = 2'b01,
      S_FULL  = 2'b11
   } state_t;

   state_t      state, state_n;
   issue_t      idex, idex_n;
   issue_t      skid, skid_n;
   issue_t      dec;
   logic [31:0] op1, op2;
   logic        accept, drain;

   assign bus.RS1_ADDR = bus.INSTR[21:17];
   assign bus.RS2_ADDR = bus.INSTR[16:12];

`ifdef ALU_ISSUE_FWD_EN
   logic fwd_ok;
   assign fwd_ok = state[0] & idex.we & ~bus.EX_STALL;
   assign op1 = (fwd_ok && bus.RS1_ADDR == idex.rd) ? bus.ALUOUT_E : bus.RS1_DATA;
   assign op2 = (fwd_ok && bus.RS2_ADDR == idex.rd) ? bus.ALUOUT_E : bus.RS2_DATA;
`else
   logic unused_aluout;
   assign unused_aluout = ^bus.ALUOUT_E;
   assign op1 = bus.RS1_DATA;
   assign op2 = bus.RS2_DATA;
`endif

   alu_issue_decode u_decode (
      .instr    (bus.INSTR),
      .rs1_data (op1),
      .rs2_data (op2),
      .dec      (dec)
   );

   assign bus.IN_READY = ~state[1];
   assign accept       = bus.IN_VALID & ~state[1];
   assign drain        = state[0] & ~bus.EX_STALL;

   always_comb begin
      state_n = state;
      idex_n  = idex;
      skid_n  = skid;
      case (state)
         S_EMPTY: begin
            if (accept) begin
               state_n = S_HOLD;
               idex_n  = dec;
            end
         end
         S_HOLD: begin
            if (accept && drain) begin
               idex_n = dec;
            end else if (accept) begin
               state_n = S_FULL;
               skid_n  = dec;
            end else if (drain) begin
               state_n = S_EMPTY;
               idex_n  = '0;
            end
         end
         S_FULL: begin
            if (drain) begin
               state_n = S_HOLD;
               idex_n  = skid;
               skid_n  = '0;
            end
         end
         default: begin
            state_n = S_EMPTY;
            idex_n  = '0;
            skid_n  = '0;
         end
      endcase
      if (bus.FLUSH) begin
         state_n = S_EMPTY;
         idex_n  = '0;
         skid_n  = '0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= S_EMPTY;
         idex  <= '0;
         skid  <= '0;
      end else begin
         state <= state_n;
         idex  <= idex_n;
         skid  <= skid_n;
      end
   end

   assign bus.VALID_E   = state[0];
   assign bus.ALUOP_E   = idex.aluop;
   assign bus.ALUSRC1   = idex.src1;
   assign bus.ALUSRC2   = idex.src2;
   assign bus.RD_E      = idex.rd;
   assign bus.WE_E      = idex.we;
   assign bus.ILLEGAL_E = idex.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - directed, table-driven self-checking bench for alu_issue_stage
module tb_alu_issue_stage;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [31:0] rf [32];
   int          errors = 0;
   int          checks = 0;

   alu_issue_stage_if #(.DW(32), .RW(5)) bus ();

   alu_issue_stage #(.DW(32), .RW(5)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   assign bus.RS1_DATA = rf[bus.RS1_ADDR];
   assign bus.RS2_DATA = rf[bus.RS2_ADDR];

   typedef struct {
      logic [31:0] instr;
      logic [3:0]  op;
      logic [31:0] s1;
      logic [31:0] s2;
      logic [4:0]  rd;
      logic        we;
      logic        ill;
   } vec_t;

   vec_t vecs[18];

   function automatic logic [31:0] rr(input logic [4:0] op, input logic [4:0] ra,
                                      input logic [4:0] rb, input logic [4:0] rc);
      return {op, ra, rb, rc, 12'h000};
   endfunction

   function automatic logic [31:0] ri(input logic [4:0] op, input logic [4:0] ra,
                                      input logic [4:0] rb, input logic [16:0] imm);
      return {op, ra, rb, imm};
   endfunction

   function automatic vec_t mkv(input logic [31:0] instr, input logic [3:0] op,
                                input logic [31:0] s1, input logic [31:0] s2,
                                input logic [4:0] rd, input logic we, input logic ill);
      vec_t v;
      v.instr = instr; v.op = op; v.s1 = s1; v.s2 = s2; v.rd = rd; v.we = we; v.ill = ill;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check_idle(input string tag);
      check({tag, " valid_e"}, {31'b0, bus.VALID_E}, 32'd0);
      check({tag, " aluop"},   {28'b0, bus.ALUOP_E}, 32'd0);
      check({tag, " src1"},    bus.ALUSRC1, 32'd0);
      check({tag, " src2"},    bus.ALUSRC2, 32'd0);
      check({tag, " rd"},      {27'b0, bus.RD_E}, 32'd0);
      check({tag, " we"},      {31'b0, bus.WE_E}, 32'd0);
      check({tag, " illegal"}, {31'b0, bus.ILLEGAL_E}, 32'd0);
   endtask

   task automatic fill_to_full(input logic [31:0] a, input logic [31:0] b);
      bus.EX_STALL = 1'b1;
      bus.IN_VALID = 1'b1;
      bus.INSTR    = a;
      tick();
      bus.INSTR    = b;
      tick();
      bus.IN_VALID = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 | i;
      rf[2] = 32'd5;
      rf[3] = 32'd7;
      rf[4] = 32'd10;
      rf[6] = 32'd0;

      vecs[0]  = mkv(rr(5'd5,  5'd1,  5'd2, 5'd3), 4'd1,  32'd5,  32'd7,        5'd1,  1'b1, 1'b0);
      vecs[1]  = mkv(ri(5'd1,  5'd21, 5'd4, 17'h1FFFF), 4'd1, 32'd10, 32'hFFFF_FFFF, 5'd21, 1'b1, 1'b0);
      vecs[2]  = mkv(ri(5'd2,  5'd22, 5'd3, 17'h0FFFF), 4'd5, 32'd7,  32'h0000_FFFF, 5'd22, 1'b1, 1'b0);
      vecs[3]  = mkv(ri(5'd3,  5'd23, 5'd2, 17'h10000), 4'd6, 32'd5,  32'hFFFF_0000, 5'd23, 1'b1, 1'b0);
      vecs[4]  = mkv(ri(5'd4,  5'd24, 5'd3, 17'h00123), 4'd12, 32'd0, 32'h0000_0123, 5'd24, 1'b1, 1'b0);
      vecs[5]  = mkv(rr(5'd6,  5'd25, 5'd4, 5'd2), 4'd2,  32'd10, 32'd5,        5'd25, 1'b1, 1'b0);
      vecs[6]  = mkv(rr(5'd7,  5'd26, 5'd2, 5'd4), 4'd3,  32'd0,  32'd10,       5'd26, 1'b1, 1'b0);
      vecs[7]  = mkv(rr(5'd8,  5'd27, 5'd3, 5'd3), 4'd4,  32'd0,  32'd7,        5'd27, 1'b1, 1'b0);
      vecs[8]  = mkv(rr(5'd9,  5'd28, 5'd2, 5'd3), 4'd5,  32'd5,  32'd7,        5'd28, 1'b1, 1'b0);
      vecs[9]  = mkv(rr(5'd10, 5'd29, 5'd4, 5'd5), 4'd6,  32'd10, 32'h1000_0005, 5'd29, 1'b1, 1'b0);
      vecs[10] = mkv(rr(5'd11, 5'd30, 5'd3, 5'd2), 4'd7,  32'd7,  32'd5,        5'd30, 1'b1, 1'b0);
      vecs[11] = mkv(rr(5'd12, 5'd20, 5'd4, 5'd3), 4'd8,  32'd10, 32'd7,        5'd20, 1'b1, 1'b0);
      vecs[12] = mkv(rr(5'd13, 5'd19, 5'd5, 5'd2), 4'd9,  32'h1000_0005, 32'd5, 5'd19, 1'b1, 1'b0);
      vecs[13] = mkv(rr(5'd14, 5'd18, 5'd2, 5'd4), 4'd10, 32'd5,  32'd10,       5'd18, 1'b1, 1'b0);
      vecs[14] = mkv(rr(5'd15, 5'd17, 5'd3, 5'd5), 4'd11, 32'd7,  32'h1000_0005, 5'd17, 1'b1, 1'b0);
      vecs[15] = mkv(rr(5'd0,  5'd31, 5'd2, 5'd3), 4'd0,  32'd0,  32'd0,        5'd31, 1'b0, 1'b0);
      vecs[16] = mkv(rr(5'd20, 5'd7,  5'd2, 5'd3), 4'd0,  32'd0,  32'd0,        5'd7,  1'b0, 1'b1);
      vecs[17] = mkv(rr(5'd31, 5'd8,  5'd2, 5'd3), 4'd0,  32'd0,  32'd0,        5'd8,  1'b0, 1'b1);

      bus.IN_VALID = 1'b0;
      bus.INSTR    = 32'h0;
      bus.EX_STALL = 1'b0;
      bus.FLUSH    = 1'b0;
      bus.ALUOUT_E = 32'hDEAD_BEEF;

      // Reset state
      RST = 1'b1;
      repeat (3) tick();
      check_idle("reset");
      RST = 1'b0;
      check("reset in_ready", {31'b0, bus.IN_READY}, 32'd1);

      // Back-to-back decode table, one instruction per cycle
      for (int i = 0; i < 18; i++) begin
         bus.IN_VALID = 1'b1;
         bus.INSTR    = vecs[i].instr;
         tick();
         check($sformatf("vec%0d valid_e", i), {31'b0, bus.VALID_E}, 32'd1);
         check($sformatf("vec%0d in_ready", i), {31'b0, bus.IN_READY}, 32'd1);
         check($sformatf("vec%0d aluop", i), {28'b0, bus.ALUOP_E}, {28'b0, vecs[i].op});
         check($sformatf("vec%0d src1", i), bus.ALUSRC1, vecs[i].s1);
         check($sformatf("vec%0d src2", i), bus.ALUSRC2, vecs[i].s2);
         check($sformatf("vec%0d rd", i), {27'b0, bus.RD_E}, {27'b0, vecs[i].rd});
         check($sformatf("vec%0d we", i), {31'b0, bus.WE_E}, {31'b0, vecs[i].we});
         check($sformatf("vec%0d illegal", i), {31'b0, bus.ILLEGAL_E}, {31'b0, vecs[i].ill});
      end
      bus.IN_VALID = 1'b0;
      tick();
      check_idle("drain_empty");

      // Stall and skid: ADD r1 (src 5,7) then SUB r9 (src 10,5)
      fill_to_full(rr(5'd5, 5'd1, 5'd2, 5'd3), rr(5'd6, 5'd9, 5'd4, 5'd2));
      check("full in_ready", {31'b0, bus.IN_READY}, 32'd0);
      check("full aluop", {28'b0, bus.ALUOP_E}, 32'd1);
      check("full src1", bus.ALUSRC1, 32'd5);
      bus.IN_VALID = 1'b1;
      bus.INSTR    = rr(5'd11, 5'd12, 5'd3, 5'd2);
      tick();
      check("full stable src2", bus.ALUSRC2, 32'd7);
      check("full stable rd", {27'b0, bus.RD_E}, 32'd1);
      check("full still not ready", {31'b0, bus.IN_READY}, 32'd0);
      bus.IN_VALID = 1'b0;
      bus.EX_STALL = 1'b0;
      tick();
      check("skid issue valid", {31'b0, bus.VALID_E}, 32'd1);
      check("skid issue aluop", {28'b0, bus.ALUOP_E}, 32'd2);
      check("skid issue src1", bus.ALUSRC1, 32'd10);
      check("skid issue src2", bus.ALUSRC2, 32'd5);
      check("skid issue rd", {27'b0, bus.RD_E}, 32'd9);
      check("release in_ready", {31'b0, bus.IN_READY}, 32'd1);
      tick();
      check_idle("skid drained");

      // Flush while FULL discards both entries and the flush-cycle offer
      fill_to_full(rr(5'd5, 5'd1, 5'd2, 5'd3), rr(5'd6, 5'd9, 5'd4, 5'd2));
      bus.FLUSH    = 1'b1;
      bus.IN_VALID = 1'b1;
      bus.INSTR    = rr(5'd9, 5'd13, 5'd2, 5'd3);
      tick();
      check_idle("flush");
      check("flush in_ready", {31'b0, bus.IN_READY}, 32'd1);
      bus.FLUSH    = 1'b0;
      bus.IN_VALID = 1'b0;
      bus.EX_STALL = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         check($sformatf("post flush %0d valid_e", k), {31'b0, bus.VALID_E}, 32'd0);
      end

      // Reset while FULL
      fill_to_full(rr(5'd5, 5'd1, 5'd2, 5'd3), rr(5'd6, 5'd9, 5'd4, 5'd2));
      RST = 1'b1;
      bus.FLUSH = 1'b1;
      tick();
      RST = 1'b0;
      bus.FLUSH = 1'b0;
      bus.EX_STALL = 1'b0;
      check_idle("reset full");
      check("reset full in_ready", {31'b0, bus.IN_READY}, 32'd1);
      tick();
      check("reset full no issue", {31'b0, bus.VALID_E}, 32'd0);

      // Forwarding: SUB r6 in ID/EX, AND reads r6 (regfile holds 0)
      bus.IN_VALID = 1'b1;
      bus.INSTR    = rr(5'd6, 5'd6, 5'd4, 5'd2);
      tick();
      bus.ALUOUT_E = 32'h0000_1234;
      bus.INSTR    = rr(5'd9, 5'd10, 5'd6, 5'd3);
      tick();
      bus.IN_VALID = 1'b0;
`ifdef ALU_ISSUE_FWD_EN
      check("fwd src1", bus.ALUSRC1, 32'h0000_1234);
`else
      check("fwd src1", bus.ALUSRC1, 32'h0000_0000);
`endif
      check("fwd src2", bus.ALUSRC2, 32'd7);
      check("fwd aluop", {28'b0, bus.ALUOP_E}, 32'd5);
      tick();
      check("fwd drained", {31'b0, bus.VALID_E}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
